// File: rtl/instr_encoder.sv
// instr_encoder
//
// Issue-side partner of the datapath instruction decoder. It takes instruction
// requests as separate fields over a valid/ready handshake and packs each one
// into the 16-bit instruction format. Packed words are buffered in a small
// circular FIFO. When issue_en allows it, the encoder presents one buffered
// word per clock on a registered output. Cycles with nothing to issue carry
// the NOP word (opcode 111).
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   in_valid     in   1      request valid
//   in_ready     out  1      encoder can accept a request (FIFO not full)
//   in_op        in   3      opcode: ADD SUB AND OR NOT LOADI (110/111 illegal)
//   in_dest      in   3      destination register
//   in_src1      in   3      source register 1
//   in_src2      in   3      source register 2
//   in_imm       in   8      immediate, LOADI only
//   issue_en     in   1      allow one FIFO entry to issue this cycle
//   instruction  out  16     registered instruction word to the decoder
//   instr_valid  out  1      instruction holds a real entry (not NOP)
//   fifo_count   out  CNT_W  entries currently buffered
//   err_illegal  out  1      one-cycle pulse after an illegal opcode is accepted

module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [2:0]       in_dest,
    input  logic [2:0]       in_src1,
    input  logic [2:0]       in_src2,
    input  logic [7:0]       in_imm,
    input  logic             issue_en,
    output logic [15:0]      instruction,
    output logic             instr_valid,
    output logic [CNT_W-1:0] fifo_count,
    output logic             err_illegal
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [15:0]      NOP_WORD = 16'hE000;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOT   = 3'b100;
    localparam logic [2:0] OP_LOADI = 3'b101;

    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [15:0]      enc_word;
    logic             legal;
    logic             accept;
    logic             push;
    logic             pop;

    // Ready depends on the count alone, so a full FIFO refuses a request
    // even in a cycle where an entry is popped.
    assign in_ready = (count_q != FULL_CNT);
    assign accept   = in_valid && in_ready;
    assign legal    = (in_op != 3'b110) && (in_op != 3'b111);
    assign push     = accept && legal;
    assign pop      = issue_en && (count_q != '0);

    // Fields the format does not use for an opcode are forced to zero,
    // whatever the requester drives on them.
    always_comb begin
        enc_word = '0;
        case (in_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR:
                enc_word = {in_op, in_dest, in_src1, in_src2, 4'b0000};
            OP_NOT:
                enc_word = {in_op, in_dest, in_src1, 7'b0000000};
            OP_LOADI:
                enc_word = {in_op, in_dest, 2'b00, in_imm};
            default:
                enc_word = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        instr_d  = NOP_WORD;
        valid_d  = 1'b0;
        err_d    = accept && !legal;

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            instr_d  = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: an entry is read only after a push has
    // written it, and reset clears the count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign fifo_count  = count_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_dest;
    logic [2:0]  in_src1;
    logic [2:0]  in_src2;
    logic [7:0]  in_imm;
    logic        issue_en;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [2:0]  fifo_count;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.DEPTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_dest     (in_dest),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .in_imm      (in_imm),
        .issue_en    (issue_en),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fifo_count  (fifo_count),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Advance one active edge, then sit 1ns past it for driving and sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [2:0] op, input logic [2:0] d,
                           input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] imm);
        in_valid = v;
        in_op    = op;
        in_dest  = d;
        in_src1  = s1;
        in_src2  = s2;
        in_imm   = imm;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        set_req(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 8'h00);
        issue_en = 1'b0;
        rst = 1'b1;
        #3;
        checks++;
        if (instruction !== 16'hE000) begin
            errors++; $display("FAIL reset_instr: got %h exp E000", instruction);
        end
        checks++;
        if (instr_valid !== 1'b0 || err_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_flags: valid=%b err=%b exp 0 0", instr_valid, err_illegal);
        end
        checks++;
        if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_count: count=%0d ready=%b exp 0 1", fifo_count, in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_add;
        issue_en = 1'b1;
        set_req(1'b1, 3'b000, 3'd1, 3'd2, 3'd3, 8'hFF);
        tick();
        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
        checks++;
        if (instruction !== 16'hE000 || instr_valid !== 1'b0 || fifo_count !== 3'd1) begin
            errors++; $display("FAIL add_no_bypass: instr=%h valid=%b count=%0d exp E000 0 1",
                               instruction, instr_valid, fifo_count);
        end
        tick();
        checks++;
        if (instruction !== 16'h0530 || instr_valid !== 1'b1 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL add_issue: instr=%h valid=%b count=%0d exp 0530 1 0",
                               instruction, instr_valid, fifo_count);
        end
        tick();
        checks++;
        if (instruction !== 16'hE000 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL add_after: instr=%h valid=%b exp E000 0", instruction, instr_valid);
        end
    endtask

    task automatic test_loadi_not;
        issue_en = 1'b1;
        set_req(1'b1, 3'b101, 3'd7, 3'b111, 3'b111, 8'hA5);
        tick();
        set_req(1'b1, 3'b100, 3'd4, 3'd5, 3'd7, 8'hFF);
        tick();
        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
        checks++;
        if (instruction !== 16'hBCA5 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL loadi_word: instr=%h valid=%b exp BCA5 1", instruction, instr_valid);
        end
        tick();
        checks++;
        if (instruction !== 16'h9280 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL not_word: instr=%h valid=%b exp 9280 1", instruction, instr_valid);
        end
        tick();
        checks++;
        if (instruction !== 16'hE000 || instr_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL loadi_not_after: instr=%h valid=%b count=%0d exp E000 0 0",
                               instruction, instr_valid, fifo_count);
        end
    endtask

    task automatic test_fill;
        logic [15:0] exp_words [5];
        exp_words[0] = 16'h0530;
        exp_words[1] = 16'h29C0;
        exp_words[2] = 16'h4E50;
        exp_words[3] = 16'h72E0;
        exp_words[4] = 16'hA03C;
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 3'(i), 3'(i + 1), 3'(i + 2), 3'(i + 3), 8'h00);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL fill_ready_%0d: got %b exp 1", i, in_ready);
            end
            tick();
        end
        set_req(1'b1, 3'b101, 3'd0, 3'd6, 3'd6, 8'h3C);
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full: count=%0d ready=%b exp 4 0", fifo_count, in_ready);
        end
        tick();
        checks++;
        if (fifo_count !== 3'd4 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL fill_hold: count=%0d valid=%b exp 4 0", fifo_count, instr_valid);
        end
        issue_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            // The held fifth request is taken on the second pop edge.
            if (i == 1) set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
            checks++;
            if (instruction !== exp_words[i] || instr_valid !== 1'b1) begin
                errors++; $display("FAIL drain_%0d: instr=%h valid=%b exp %h 1",
                                   i, instruction, instr_valid, exp_words[i]);
            end
            checks++;
            if (fifo_count !== 3'(i == 0 ? 3 : 4 - i)) begin
                errors++; $display("FAIL drain_count_%0d: got %0d exp %0d",
                                   i, fifo_count, (i == 0 ? 3 : 4 - i));
            end
        end
        tick();
        checks++;
        if (instruction !== 16'hE000 || instr_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL empty_nop: instr=%h valid=%b count=%0d exp E000 0 0",
                               instruction, instr_valid, fifo_count);
        end
    endtask

    task automatic test_illegal;
        issue_en = 1'b1;
        set_req(1'b1, 3'b110, 3'd1, 3'd1, 3'd1, 8'h11);
        tick();
        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
        checks++;
        if (err_illegal !== 1'b1 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL illegal_pulse: err=%b count=%0d exp 1 0", err_illegal, fifo_count);
        end
        tick();
        checks++;
        if (err_illegal !== 1'b0 || instruction !== 16'hE000 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_after: err=%b instr=%h valid=%b exp 0 E000 0",
                               err_illegal, instruction, instr_valid);
        end
        // Illegal opcode presented while full is never accepted.
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 3'b000, 3'd1, 3'd2, 3'd3, 8'h00);
            tick();
        end
        set_req(1'b1, 3'b111, 3'd0, 3'd0, 3'd0, 8'h00);
        tick();
        tick();
        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
        checks++;
        if (err_illegal !== 1'b0 || fifo_count !== 3'd4) begin
            errors++; $display("FAIL illegal_full: err=%b count=%0d exp 0 4", err_illegal, fifo_count);
        end
        issue_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (fifo_count !== 3'd0 || err_illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_drain: count=%0d err=%b exp 0 0", fifo_count, err_illegal);
        end
    endtask

    task automatic test_wrap;
        int issued;
        logic [15:0] exp_w;
        issued = 0;
        issue_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) set_req(1'b1, 3'b101, 3'(c % 8), 3'b111, 3'b111, 8'(8'h10 + c));
            else        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
            tick();
            if (c >= 1 && c <= 10) exp_w = 16'hA000 | 16'(((c - 1) % 8) << 10) | 16'(8'h10 + c - 1);
            else                   exp_w = 16'hE000;
            if (instr_valid === 1'b1) issued++;
            checks++;
            if (instruction !== exp_w || instr_valid !== (c >= 1 && c <= 10)) begin
                errors++; $display("FAIL wrap_%0d: instr=%h valid=%b exp %h", c, instruction, instr_valid, exp_w);
            end
        end
        checks++;
        if (issued != 10) begin
            errors++; $display("FAIL wrap_total: issued %0d exp 10", issued);
        end
    endtask

    task automatic test_reset_mid;
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 3'b000, 3'd1, 3'd2, 3'd3, 8'h00);
            tick();
        end
        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
        checks++;
        if (instruction !== 16'h0530 || fifo_count !== 3'd3) begin
            errors++; $display("FAIL pre_reset: instr=%h count=%0d exp 0530 3", instruction, fifo_count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (instruction !== 16'hE000 || fifo_count !== 3'd0 || instr_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: instr=%h count=%0d valid=%b ready=%b exp E000 0 0 1",
                               instruction, fifo_count, instr_valid, in_ready);
        end
        #1;
        rst = 1'b0;
        issue_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (instruction !== 16'hE000 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL post_reset_nop_%0d: instr=%h valid=%b exp E000 0",
                                   i, instruction, instr_valid);
            end
        end
        set_req(1'b1, 3'b011, 3'd4, 3'd5, 3'd6, 8'h00);
        tick();
        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
        tick();
        checks++;
        if (instruction !== 16'h72E0 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL post_reset_push: instr=%h valid=%b exp 72E0 1", instruction, instr_valid);
        end
    endtask

    initial begin
        rst = 1'b0;
        issue_en = 1'b0;
        set_req(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00);
        #2;
        test_reset();
        test_add();
        test_loadi_not();
        test_fill();
        test_illegal();
        test_wrap();
        test_reset_mid();
        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
